// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter: shares one synchronous single-port RAM between NUM_CH
// requesters. Channel 0 (debugger) always wins. Channels 1..NUM_CH-1 use
// fixed priority (lowest index wins) by default. Defining ARB_ROUND_ROBIN_EN
// builds a rotating-priority pointer for those channels instead.
// Read data returns READ_LATENCY cycles after the address, is captured into a
// per-channel hold register, and is flagged by a one-cycle o_valid pulse.
//
// Handshake: i_req[k] acts as valid and o_grant[k] acts as ready. An access
// transfers in any cycle where both are high. A requester keeps i_req,
// i_rw, address and data stable until it sees its grant. There is no queuing.
module mem_port_arbiter #(
  parameter int NUM_CH       = 2,
  parameter int ADDR_W       = 16,
  parameter int DATA_W       = 8,
  parameter int READ_LATENCY = 1
) (
  input  logic                     i_clk,
  input  logic                     i_reset,
  input  logic [NUM_CH-1:0]        i_req,
  input  logic [NUM_CH-1:0]        i_rw,
  input  logic [NUM_CH*ADDR_W-1:0] i_address,
  input  logic [NUM_CH*DATA_W-1:0] i_data,
  output logic [NUM_CH-1:0]        o_grant,
  output logic [NUM_CH*DATA_W-1:0] o_data,
  output logic [NUM_CH-1:0]        o_valid,
  output logic                     o_mem_en,
  output logic                     o_mem_wea,
  output logic [ADDR_W-1:0]        o_mem_address,
  output logic [DATA_W-1:0]        o_mem_data,
  input  logic [DATA_W-1:0]        i_mem_data
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;
  localparam logic [CH_W-1:0] FIRST_CH = CH_W'(1);
  localparam logic [CH_W-1:0] LAST_CH  = CH_W'(NUM_CH - 1);

  logic [NUM_CH-1:0] grant;
  logic [CH_W-1:0]   gidx;
  logic              found;
  int                cand;
  logic [CH_W-1:0]   cand_idx;
  logic              any_grant;
  logic              rd_push;

`ifdef ARB_ROUND_ROBIN_EN
  // Channel that gets first look among 1..NUM_CH-1 in the current cycle
  logic [CH_W-1:0]   rr_ptr;
`endif

  // Read tags: one entry per RAM latency stage, carrying the owning channel
  logic              tag_vld [READ_LATENCY];
  logic [CH_W-1:0]   tag_ch  [READ_LATENCY];
  logic              out_vld;
  logic [CH_W-1:0]   out_ch;

  // Pick the winner: channel 0 first, then the masters in priority order
  always_comb begin
    grant    = '0;
    gidx     = '0;
    found    = 1'b0;
    cand     = 0;
    cand_idx = '0;
    if (i_req[0]) begin
      grant[0] = 1'b1;
      found    = 1'b1;
    end else begin
      for (int i = 0; i < NUM_CH - 1; i++) begin
`ifdef ARB_ROUND_ROBIN_EN
        cand = int'(rr_ptr) + i;
        if (cand > NUM_CH - 1) cand = cand - (NUM_CH - 1);
`else
        cand = i + 1;
`endif
        cand_idx = CH_W'(cand);
        if (!found && i_req[cand_idx]) begin
          found           = 1'b1;
          gidx            = cand_idx;
          grant[cand_idx] = 1'b1;
        end
      end
    end
  end

  assign any_grant = |grant;
  assign rd_push   = any_grant & i_rw[gidx];
  assign o_grant   = grant;
  assign o_mem_en  = any_grant;
  assign o_mem_wea = any_grant & ~i_rw[gidx];
  assign o_mem_address = any_grant ? i_address[int'(gidx)*ADDR_W +: ADDR_W] : '0;
  assign o_mem_data    = any_grant ? i_data[int'(gidx)*DATA_W +: DATA_W] : '0;

`ifdef ARB_ROUND_ROBIN_EN
  // Advance the pointer past the master just served; channel 0 and idle leave it alone
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      rr_ptr <= FIRST_CH;
    end else if (any_grant && (gidx != '0)) begin
      rr_ptr <= (gidx == LAST_CH) ? FIRST_CH : gidx + FIRST_CH;
    end
  end
`endif

  // Shift read tags alongside the RAM's own latency; reset drops anything in flight
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      for (int s = 0; s < READ_LATENCY; s++) begin
        tag_vld[s] <= 1'b0;
        tag_ch[s]  <= '0;
      end
    end else begin
      tag_vld[0] <= rd_push;
      tag_ch[0]  <= gidx;
      for (int s = 1; s < READ_LATENCY; s++) begin
        tag_vld[s] <= tag_vld[s-1];
        tag_ch[s]  <= tag_ch[s-1];
      end
    end
  end

  assign out_vld = tag_vld[READ_LATENCY-1];
  assign out_ch  = tag_ch[READ_LATENCY-1];

  // Capture returning RAM data into the owning channel's hold register and pulse its valid
  always_ff @(posedge i_clk or posedge i_reset) begin
    if (i_reset) begin
      o_data  <= '0;
      o_valid <= '0;
    end else begin
      o_valid <= '0;
      if (out_vld) begin
        o_valid[out_ch]                          <= 1'b1;
        o_data[int'(out_ch)*DATA_W +: DATA_W]    <= i_mem_data;
      end
    end
  end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter: drives two arbiter instances side by side.
//   inst 0 (A): NUM_CH=2, READ_LATENCY=1
//   inst 1 (B): NUM_CH=4, READ_LATENCY=2
// Inputs change 2 time units after each rising edge; outputs are observed at
// the falling edge. A behavioural scoreboard predicts grant, RAM drive and
// read returns for both instances every cycle from the rules of the block.
module tb_mem_port_arbiter;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;
  int cyc   = 0;

  // ---------------- stimulus (per instance, padded to 4 channels) ----------------
  logic [3:0]  req    [2];
  logic [3:0]  rw     [2];
  logic [63:0] addr_f [2];
  logic [31:0] wd_f   [2];

  // ---------------- DUT outputs ----------------
  logic [1:0]  a_grant, a_valid;
  logic [15:0] a_odata;
  logic        a_en, a_wea;
  logic [15:0] a_maddr;
  logic [7:0]  a_mwd;
  logic [7:0]  a_mrd = 8'h00;

  logic [3:0]  b_grant, b_valid;
  logic [31:0] b_odata;
  logic        b_en, b_wea;
  logic [15:0] b_maddr;
  logic [7:0]  b_mwd;
  logic [7:0]  b_mrd = 8'h00;
  logic [7:0]  b_s1  = 8'h00;

  logic [3:0]  gnt   [2];
  logic [3:0]  vld   [2];
  logic [31:0] odat  [2];
  logic        en    [2];
  logic        wea   [2];
  logic [15:0] maddr [2];
  logic [7:0]  mwd   [2];

  assign gnt[0]   = {2'b00, a_grant};
  assign gnt[1]   = b_grant;
  assign vld[0]   = {2'b00, a_valid};
  assign vld[1]   = b_valid;
  assign odat[0]  = {16'h0000, a_odata};
  assign odat[1]  = b_odata;
  assign en[0]    = a_en;
  assign en[1]    = b_en;
  assign wea[0]   = a_wea;
  assign wea[1]   = b_wea;
  assign maddr[0] = a_maddr;
  assign maddr[1] = b_maddr;
  assign mwd[0]   = a_mwd;
  assign mwd[1]   = b_mwd;

  mem_port_arbiter #(.NUM_CH(2), .ADDR_W(16), .DATA_W(8), .READ_LATENCY(1)) u_a (
    .i_clk(clk), .i_reset(rst),
    .i_req(req[0][1:0]), .i_rw(rw[0][1:0]),
    .i_address(addr_f[0][31:0]), .i_data(wd_f[0][15:0]),
    .o_grant(a_grant), .o_data(a_odata), .o_valid(a_valid),
    .o_mem_en(a_en), .o_mem_wea(a_wea), .o_mem_address(a_maddr),
    .o_mem_data(a_mwd), .i_mem_data(a_mrd));

  mem_port_arbiter #(.NUM_CH(4), .ADDR_W(16), .DATA_W(8), .READ_LATENCY(2)) u_b (
    .i_clk(clk), .i_reset(rst),
    .i_req(req[1]), .i_rw(rw[1]),
    .i_address(addr_f[1]), .i_data(wd_f[1]),
    .o_grant(b_grant), .o_data(b_odata), .o_valid(b_valid),
    .o_mem_en(b_en), .o_mem_wea(b_wea), .o_mem_address(b_maddr),
    .o_mem_data(b_mwd), .i_mem_data(b_mrd));

  // ---------------- RAM models (write-first) ----------------
  logic [7:0] ram [int];
  logic [7:0] shd [int];

  function automatic logic [7:0] init_val(input logic [15:0] a);
    return a[7:0] + 8'h90;
  endfunction

  function automatic int key(input int k, input logic [15:0] a);
    return k * 65536 + int'(a);
  endfunction

  always @(posedge clk) begin
    if (a_en) begin
      if (a_wea) ram[key(0, a_maddr)] = a_mwd;
      a_mrd <= ram.exists(key(0, a_maddr)) ? ram[key(0, a_maddr)] : init_val(a_maddr);
    end
  end

  always @(posedge clk) begin
    if (b_en) begin
      if (b_wea) ram[key(1, b_maddr)] = b_mwd;
      b_s1 <= ram.exists(key(1, b_maddr)) ? ram[key(1, b_maddr)] : init_val(b_maddr);
    end
    b_mrd <= b_s1;
  end

  // ---------------- reference model ----------------
  // Winner for a request vector: channel 0 first, then search 1..n-1 from p.
  // In the fixed-priority build p stays at 1, giving lowest-index order.
  function automatic int model_grant(input logic [3:0] r, input int n, input int p);
    if (r[0]) return 0;
    for (int i = 0; i < n - 1; i++) begin
      int c;
      c = ((p - 1 + i) % (n - 1)) + 1;
      if (r[c]) return c;
    end
    return -1;
  endfunction

  // Expected read returns: {data[31:24], ch[23:20], inst[19:16], due_cycle[15:0]}
  logic [31:0] exp_q [$];
  logic [31:0] exp_od [2];
  int          ptr [2];

  initial begin
    exp_od[0] = '0;
    exp_od[1] = '0;
    ptr[0] = 1;
    ptr[1] = 1;
  end

  // ---------------- scoreboard ----------------
  always @(negedge clk) begin : scoreboard
    logic [3:0]  ev;
    logic [31:0] keep_q [$];
    int          g, n, lat;
    logic [3:0]  eg;
    logic [15:0] ea;
    logic [7:0]  ed;
    cyc++;
    if (rst) begin
      exp_q.delete();
      exp_od[0] = '0;
      exp_od[1] = '0;
      ptr[0] = 1;
      ptr[1] = 1;
    end
    for (int k = 0; k < 2; k++) begin
      n   = (k == 0) ? 2 : 4;
      lat = (k == 0) ? 1 : 2;
      ev  = '0;
      keep_q.delete();
      foreach (exp_q[j]) begin
        if (int'(exp_q[j][19:16]) == k && exp_q[j][15:0] == 16'(cyc)) begin
          ev[exp_q[j][23:20]] = 1'b1;
          exp_od[k][int'(exp_q[j][23:20])*8 +: 8] = exp_q[j][31:24];
        end else begin
          keep_q.push_back(exp_q[j]);
        end
      end
      exp_q = keep_q;
      tests++;
      if (vld[k] !== ev) begin
        fails++;
        $display("FAIL sb_valid inst%0d cyc%0d: got %b expected %b", k, cyc, vld[k], ev);
      end
      tests++;
      if (odat[k] !== exp_od[k]) begin
        fails++;
        $display("FAIL sb_data inst%0d cyc%0d: got %h expected %h", k, cyc, odat[k], exp_od[k]);
      end
      g  = model_grant(req[k], n, ptr[k]);
      eg = (g < 0) ? 4'b0000 : 4'(1 << g);
      ea = (g < 0) ? 16'h0000 : addr_f[k][g*16 +: 16];
      ed = (g < 0) ? 8'h00 : wd_f[k][g*8 +: 8];
      tests++;
      if (gnt[k] !== eg) begin
        fails++;
        $display("FAIL sb_grant inst%0d cyc%0d: got %b expected %b", k, cyc, gnt[k], eg);
      end
      tests++;
      if (en[k] !== (g >= 0) || wea[k] !== (g >= 0 && !rw[k][g])) begin
        fails++;
        $display("FAIL sb_en_wea inst%0d cyc%0d: got en=%b wea=%b", k, cyc, en[k], wea[k]);
      end
      tests++;
      if (maddr[k] !== ea || mwd[k] !== ((g >= 0 && !rw[k][g]) ? ed : mwd[k])) begin
        fails++;
        $display("FAIL sb_mem_bus inst%0d cyc%0d: got addr=%h data=%h expected addr=%h", k, cyc, maddr[k], mwd[k], ea);
      end
      if (g >= 0) begin
        if (!rw[k][g]) begin
          shd[key(k, ea)] = ed;
        end else if (!rst) begin
          exp_q.push_back({(shd.exists(key(k, ea)) ? shd[key(k, ea)] : init_val(ea)),
                           4'(g), 4'(k), 16'(cyc + lat + 1)});
        end
`ifdef ARB_ROUND_ROBIN_EN
        if (!rst && g >= 1) ptr[k] = (g == n - 1) ? 1 : g + 1;
`endif
      end
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mid();
    @(negedge clk);
    #1;
  endtask

  task automatic set_ch(input int k, input int c, input logic r, input logic w,
                        input logic [15:0] a, input logic [7:0] d);
    req[k][c] = r;
    rw[k][c]  = w;
    addr_f[k][c*16 +: 16] = a;
    wd_f[k][c*8 +: 8]     = d;
  endtask

  task automatic idle_all();
    req[0] = '0;
    req[1] = '0;
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    mid();
    tests++;
    if (a_valid !== 2'b00 || a_odata !== 16'h0 || b_valid !== 4'b0 || b_odata !== 32'h0) begin
      fails++;
      $display("FAIL reset_regs: a_valid=%b a_data=%h b_valid=%b b_data=%h", a_valid, a_odata, b_valid, b_odata);
    end
    tests++;
    if (a_grant !== 2'b00 || a_en !== 1'b0) begin
      fails++;
      $display("FAIL reset_idle: grant=%b en=%b expected 00/0", a_grant, a_en);
    end
    set_ch(0, 1, 1'b1, 1'b1, 16'h0077, 8'h00);
    mid();
    tests++;
    if (a_grant !== 2'b10 || a_en !== 1'b1 || a_maddr !== 16'h0077) begin
      fails++;
      $display("FAIL reset_comb_grant: grant=%b en=%b addr=%h expected 10/1/0077", a_grant, a_en, a_maddr);
    end
    idle_all();
    tick();
    rst = 1'b0;
    tick();
  endtask

  task automatic test_fairness();
    int seq [6];
`ifdef ARB_ROUND_ROBIN_EN
    seq = '{1, 2, 3, 1, 2, 3};
`else
    seq = '{1, 1, 1, 1, 1, 1};
`endif
    for (int c = 1; c < 4; c++) set_ch(1, c, 1'b1, 1'b1, 16'(16'h0040 + c), 8'h00);
    for (int i = 0; i < 6; i++) begin
      mid();
      tests++;
      if (b_grant !== 4'(1 << seq[i])) begin
        fails++;
        $display("FAIL fairness step%0d: grant=%b expected %b", i, b_grant, 4'(1 << seq[i]));
      end
      tick();
    end
    idle_all();
    repeat (4) tick();
  endtask

  task automatic test_write_read();
    set_ch(0, 1, 1'b1, 1'b0, 16'h0200, 8'h5A);
    mid();
    tests++;
    if (a_grant !== 2'b10 || a_wea !== 1'b1 || a_maddr !== 16'h0200 || a_mwd !== 8'h5A) begin
      fails++;
      $display("FAIL wr_grant: grant=%b wea=%b addr=%h data=%h", a_grant, a_wea, a_maddr, a_mwd);
    end
    tick();
    set_ch(0, 1, 1'b1, 1'b1, 16'h0200, 8'h00);
    mid();
    tests++;
    if (a_grant !== 2'b10 || a_wea !== 1'b0 || a_valid !== 2'b00) begin
      fails++;
      $display("FAIL rd_grant: grant=%b wea=%b valid=%b", a_grant, a_wea, a_valid);
    end
    tick();
    idle_all();
    mid();
    tests++;
    if (a_valid !== 2'b00) begin
      fails++;
      $display("FAIL rd_early_valid: valid=%b expected 00", a_valid);
    end
    tick();
    mid();
    tests++;
    if (a_valid !== 2'b10 || a_odata !== 16'h5A00) begin
      fails++;
      $display("FAIL rd_return: valid=%b data=%h expected 10/5a00", a_valid, a_odata);
    end
    tick();
    mid();
    tests++;
    if (a_valid !== 2'b00 || a_odata !== 16'h5A00) begin
      fails++;
      $display("FAIL rd_hold: valid=%b data=%h expected 00/5a00", a_valid, a_odata);
    end
    tick();
  endtask

  task automatic test_conflict();
    set_ch(0, 0, 1'b1, 1'b1, 16'h0030, 8'h00);
    set_ch(0, 1, 1'b1, 1'b1, 16'h0031, 8'h00);
    mid();
    tests++;
    if (a_grant !== 2'b01 || a_maddr !== 16'h0030) begin
      fails++;
      $display("FAIL conflict_ch0: grant=%b addr=%h expected 01/0030", a_grant, a_maddr);
    end
    tick();
    req[0][0] = 1'b0;
    mid();
    tests++;
    if (a_grant !== 2'b10 || a_maddr !== 16'h0031) begin
      fails++;
      $display("FAIL conflict_ch1: grant=%b addr=%h expected 10/0031", a_grant, a_maddr);
    end
    tick();
    idle_all();
    mid();
    tests++;
    if (a_valid !== 2'b01 || a_odata[7:0] !== 8'hC0) begin
      fails++;
      $display("FAIL conflict_ret0: valid=%b data=%h expected 01/c0", a_valid, a_odata[7:0]);
    end
    tick();
    mid();
    tests++;
    if (a_valid !== 2'b10 || a_odata !== 16'hC1C0) begin
      fails++;
      $display("FAIL conflict_ret1: valid=%b data=%h expected 10/c1c0", a_valid, a_odata);
    end
    tick();
  endtask

  task automatic test_pipeline();
    for (int i = 0; i < 3; i++) begin
      set_ch(1, 1, 1'b1, 1'b1, 16'(16'h0010 + i), 8'h00);
      if (i < 2) tick();
    end
    mid();
    tests++;
    if (b_valid !== 4'b0000) begin
      fails++;
      $display("FAIL pipe_early: valid=%b expected 0000", b_valid);
    end
    tick();
    idle_all();
    for (int i = 0; i < 3; i++) begin
      mid();
      tests++;
      if (b_valid !== 4'b0010 || b_odata[15:8] !== 8'(8'hA0 + i)) begin
        fails++;
        $display("FAIL pipe_beat%0d: valid=%b data=%h expected 0010/%h", i, b_valid, b_odata[15:8], 8'(8'hA0 + i));
      end
      tick();
    end
    mid();
    tests++;
    if (b_valid !== 4'b0000 || b_odata[15:8] !== 8'hA2) begin
      fails++;
      $display("FAIL pipe_hold: valid=%b data=%h expected 0000/a2", b_valid, b_odata[15:8]);
    end
    tick();
  endtask

  task automatic test_idle();
    idle_all();
    repeat (3) begin
      mid();
      tests++;
      if (a_en !== 1'b0 || a_wea !== 1'b0 || a_grant !== 2'b00 || a_valid !== 2'b00 ||
          b_en !== 1'b0 || b_wea !== 1'b0 || b_grant !== 4'b0000 || b_valid !== 4'b0000) begin
        fails++;
        $display("FAIL idle: a en/wea/grant/valid=%b%b/%b/%b b=%b%b/%b/%b",
                 a_en, a_wea, a_grant, a_valid, b_en, b_wea, b_grant, b_valid);
      end
      tick();
    end
  endtask

  task automatic test_reset_mid_read();
    set_ch(0, 1, 1'b1, 1'b1, 16'h0200, 8'h00);
    mid();
    tests++;
    if (a_grant !== 2'b10) begin
      fails++;
      $display("FAIL rst_mid_grant: grant=%b expected 10", a_grant);
    end
    tick();
    idle_all();
    rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      mid();
      tests++;
      if (a_valid !== 2'b00 || a_odata !== 16'h0000) begin
        fails++;
        $display("FAIL rst_mid_in_reset: valid=%b data=%h expected 00/0000", a_valid, a_odata);
      end
      tick();
    end
    rst = 1'b0;
    for (int i = 0; i < 3; i++) begin
      mid();
      tests++;
      if (a_valid !== 2'b00 || a_odata[15:8] !== 8'h00) begin
        fails++;
        $display("FAIL rst_mid_after: valid=%b data=%h expected 00/00", a_valid, a_odata[15:8]);
      end
      tick();
    end
  endtask

  task automatic test_random();
    logic [3:0] last_gnt [2];
    last_gnt[0] = '0;
    last_gnt[1] = '0;
    for (int t = 0; t < 400; t++) begin
      for (int k = 0; k < 2; k++) begin
        for (int c = 0; c < ((k == 0) ? 2 : 4); c++) begin
          if (!(req[k][c] && !last_gnt[k][c])) begin
            set_ch(k, c, ($urandom_range(0, 99) < ((c == 0) ? 15 : 45)),
                   1'($urandom_range(0, 1)),
                   16'(16'h0100 + $urandom_range(0, 7)),
                   8'($urandom_range(0, 255)));
          end
        end
      end
      mid();
      last_gnt[0] = gnt[0];
      last_gnt[1] = gnt[1];
      tick();
    end
    idle_all();
    repeat (6) tick();
    mid();
    tests++;
    if (exp_q.size() != 0) begin
      fails++;
      $display("FAIL random_drain: %0d expected returns never arrived", exp_q.size());
    end
  endtask

  // ---------------- sequence and report ----------------
  initial begin
    req[0] = '0; req[1] = '0;
    rw[0] = '0; rw[1] = '0;
    addr_f[0] = '0; addr_f[1] = '0;
    wd_f[0] = '0; wd_f[1] = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #2;
    test_reset();
    test_fairness();
    test_write_read();
    test_conflict();
    test_pipeline();
    test_idle();
    test_reset_mid_read();
    test_random();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
